// File: rtl/i2c_slv_l2_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// i2c_slv_l2_dma_ctrl_if
// Groups the RX byte stream (from the I2C slave) and the L2 req/gnt write
// port of the I2C-to-L2 DMA controller.
//   rx_valid_i / rx_data_i / rx_ready_o : byte stream, accepted on valid&ready
//   mem_req_o / mem_addr_o / mem_wdata_o / mem_be_o / mem_gnt_i :
//      word write port, transfer completes in the cycle req & gnt
// Modports:
//   master : the DMA controller (consumes bytes, issues memory writes)
//   slave  : the environment (byte source + memory)
// ---------------------------------------------------------------------------
interface i2c_slv_l2_dma_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();

   logic                  rx_valid_i;
   logic [7:0]            rx_data_i;
   logic                  rx_ready_o;

   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [3:0]            mem_be_o;
   logic                  mem_gnt_i;

   modport master (
      input  rx_valid_i,
      input  rx_data_i,
      output rx_ready_o,
      output mem_req_o,
      output mem_addr_o,
      output mem_wdata_o,
      output mem_be_o,
      input  mem_gnt_i
   );

   modport slave (
      output rx_valid_i,
      output rx_data_i,
      input  rx_ready_o,
      input  mem_req_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      input  mem_be_o,
      output mem_gnt_i
   );

endinterface

// File: rtl/i2c_slv_l2_dma_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slv_l2_dma_ctrl
// Moves bytes received by the I2C slave into an L2 buffer without core
// involvement. Bytes are packed little-endian into 32-bit words and written
// through a req/gnt port; an interrupt pulse marks the end of a message
// (I2C stop), after which firmware can read the whole message from L2.
//
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   cfg_en_i               : controller enable (live)
//   cfg_irq_en_i           : interrupt enable (live)
//   cfg_base_addr_i        : L2 buffer base, bits [1:0] ignored
//   cfg_len_i              : buffer capacity in bytes
//   start_i / stop_i       : 1-cycle I2C start(+addr match) / stop pulses
//   bus (master modport)   : RX byte stream + L2 write port
//   busy_o                 : high outside IDLE
//   byte_cnt_o             : bytes stored for the current/last message
//   ovf_o                  : sticky, bytes dropped because buffer was full
//   irq_o                  : 1-cycle completion pulse
// ---------------------------------------------------------------------------
module i2c_slv_l2_dma_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cfg_en_i,
   input  logic                  cfg_irq_en_i,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
   input  logic [LEN_WIDTH-1:0]  cfg_len_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   i2c_slv_l2_dma_ctrl_if.master bus,
   output logic                  busy_o,
   output logic [LEN_WIDTH-1:0]  byte_cnt_o,
   output logic                  ovf_o,
   output logic                  irq_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]            state_q,     state_d;
   logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
   logic [31:0]           wdata_q,     wdata_d;
   logic [3:0]            be_q,        be_d;
   logic [1:0]            lane_q,      lane_d;
   logic [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
   logic [LEN_WIDTH-1:0]  len_q,       len_d;
   logic                  ovf_q,       ovf_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  rx_ready_q,  rx_ready_d;
   logic                  mem_req_q,   mem_req_d;
   logic                  busy_q,      busy_d;
   logic                  irq_q,       irq_d;

   logic                  byte_acc;
   logic                  word_done;

   assign byte_acc  = bus.rx_valid_i & rx_ready_q;
   assign word_done = mem_req_q & bus.mem_gnt_i;

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      ovf_d       = ovf_q;
      stop_pend_d = stop_pend_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && cfg_en_i) begin
               state_d     = S_COLLECT;
               // masking keeps the low address bits word aligned
               ptr_d       = cfg_base_addr_i & ~ADDR_WIDTH'(3);
               len_d       = cfg_len_i;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               lane_d      = 2'd0;
               be_d        = 4'd0;
               wdata_d     = 32'd0;
               stop_pend_d = 1'b0;
            end
         end

         S_COLLECT: begin
            if (!cfg_en_i) begin
               // abort: partial word is discarded, no interrupt
               state_d     = S_IDLE;
               lane_d      = 2'd0;
               be_d        = 4'd0;
               wdata_d     = 32'd0;
               stop_pend_d = 1'b0;
            end else begin
               if (byte_acc) begin
                  if (cnt_q < len_q) begin
                     wdata_d[{lane_q, 3'b000} +: 8] = bus.rx_data_i;
                     be_d[lane_q] = 1'b1;
                     lane_d       = lane_q + 2'd1;
                     cnt_d        = cnt_q + LEN_WIDTH'(1);
                     if (lane_q == 2'd3) begin
                        state_d = S_WRITE;
                     end
                  end else begin
                     // buffer full: still acknowledged so SCL is never held
                     ovf_d = 1'b1;
                  end
               end
               // stop is evaluated after the byte above, so be_d covers both
               if (stop_i) begin
                  stop_pend_d = 1'b1;
                  state_d     = (be_d != 4'd0) ? S_WRITE : S_DONE;
               end
            end
         end

         S_WRITE: begin
            if (stop_i) begin
               stop_pend_d = 1'b1;
            end
            if (word_done) begin
               ptr_d   = ptr_q + ADDR_WIDTH'(4);
               be_d    = 4'd0;
               lane_d  = 2'd0;
               wdata_d = 32'd0;
               if (!cfg_en_i) begin
                  state_d     = S_IDLE;
                  stop_pend_d = 1'b0;
               end else if (stop_pend_q || stop_i) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end

         S_DONE: begin
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // registered outputs follow the state being entered
      rx_ready_d = (state_d == S_COLLECT);
      mem_req_d  = (state_d == S_WRITE);
      busy_d     = (state_d != S_IDLE);
      irq_d      = (state_d == S_DONE) && cfg_irq_en_i;
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         lane_q      <= 2'd0;
         cnt_q       <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         stop_pend_q <= 1'b0;
         rx_ready_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         stop_pend_q <= stop_pend_d;
         rx_ready_q  <= rx_ready_d;
         mem_req_q   <= mem_req_d;
         busy_q      <= busy_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.rx_ready_o  = rx_ready_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_addr_o  = ptr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.mem_be_o    = be_q;
   assign busy_o          = busy_q;
   assign byte_cnt_o      = cnt_q;
   assign ovf_o           = ovf_q;
   assign irq_o           = irq_q;

endmodule
